// File: rtl/ysyx_23060236_mem_arbiter_if.sv
// AXI4-Lite-style link (ar/r/aw/w/b channels) between one master and one slave.
// IFU links leave the write channels idle.
interface ysyx_23060236_mem_arbiter_if;
  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned STRB_W = DATA_W / 8;

  logic [ADDR_W-1:0] araddr;
  logic [2:0]        arsize;
  logic              arvalid;
  logic              arready;
  logic [DATA_W-1:0] rdata;
  logic [1:0]        rresp;
  logic              rvalid;
  logic              rready;
  logic [ADDR_W-1:0] awaddr;
  logic [2:0]        awsize;
  logic              awvalid;
  logic              awready;
  logic [DATA_W-1:0] wdata;
  logic [STRB_W-1:0] wstrb;
  logic              wvalid;
  logic              wready;
  logic [1:0]        bresp;
  logic              bvalid;
  logic              bready;

  modport master (
    output araddr, arsize, arvalid, rready,
    output awaddr, awsize, awvalid, wdata, wstrb, wvalid, bready,
    input  arready, rdata, rresp, rvalid,
    input  awready, wready, bresp, bvalid
  );

  modport slave (
    input  araddr, arsize, arvalid, rready,
    input  awaddr, awsize, awvalid, wdata, wstrb, wvalid, bready,
    output arready, rdata, rresp, rvalid,
    output awready, wready, bresp, bvalid
  );
endinterface

// File: rtl/ysyx_23060236_mem_arbiter.sv
// Shares one memory port between the IFU (read-only) and the LSU (read/write).
// A grant is held for one whole transaction; a sticky watchdog flags transactions that never close.
module ysyx_23060236_mem_arbiter #(
  parameter bit          RR_EN       = 1'b1,
  parameter int unsigned HANG_CYCLES = 1024
) (
  input  logic                               clock,
  input  logic                               reset,
  ysyx_23060236_mem_arbiter_if.slave         ifu,
  ysyx_23060236_mem_arbiter_if.slave         lsu,
  ysyx_23060236_mem_arbiter_if.master        s,
  output logic                               hang_flag
);
  localparam int unsigned      CNT_W    = $clog2(HANG_CYCLES) + 1;
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(HANG_CYCLES);
  localparam logic [2:0]       IFU_SIZE = 3'b010;

  typedef enum logic [1:0] {IDLE, IFU_RD, LSU_RD, LSU_WR} state_e;
  typedef enum logic {GNT_IFU, GNT_LSU} gnt_e;

  state_e           state_q, state_d;
  gnt_e             grant_last_q, grant_last_d;
  logic             ar_done_q, ar_done_d;
  logic             aw_done_q, aw_done_d;
  logic             w_done_q, w_done_d;
  logic [CNT_W-1:0] hang_cnt_q, hang_cnt_d;
  logic             hang_flag_q, hang_flag_d;

  // The IFU never writes and always fetches 32-bit words.
  logic unused_ifu_in;
  assign unused_ifu_in = ^{ifu.arsize, ifu.awaddr, ifu.awsize, ifu.awvalid,
                           ifu.wdata, ifu.wstrb, ifu.wvalid, ifu.bready};

  // State register
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q      <= IDLE;
      grant_last_q <= GNT_LSU;
      ar_done_q    <= 1'b0;
      aw_done_q    <= 1'b0;
      w_done_q     <= 1'b0;
      hang_cnt_q   <= '0;
      hang_flag_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      grant_last_q <= grant_last_d;
      ar_done_q    <= ar_done_d;
      aw_done_q    <= aw_done_d;
      w_done_q     <= w_done_d;
      hang_cnt_q   <= hang_cnt_d;
      hang_flag_q  <= hang_flag_d;
    end
  end

  assign hang_flag = hang_flag_q;

  // Grant selection and transaction close
  always_comb begin
    state_d      = state_q;
    grant_last_d = grant_last_q;
    unique case (state_q)
      IDLE: begin
        if (lsu.awvalid || lsu.wvalid) begin
          state_d = LSU_WR;
        end else if (lsu.arvalid && ifu.arvalid) begin
          state_d = (RR_EN && (grant_last_q == GNT_LSU)) ? IFU_RD : LSU_RD;
        end else if (lsu.arvalid) begin
          state_d = LSU_RD;
        end else if (ifu.arvalid) begin
          state_d = IFU_RD;
        end
      end
      IFU_RD: begin
        if (s.rvalid && s.rready) begin
          state_d      = IDLE;
          grant_last_d = GNT_IFU;
        end
      end
      LSU_RD: begin
        if (s.rvalid && s.rready) begin
          state_d      = IDLE;
          grant_last_d = GNT_LSU;
        end
      end
      LSU_WR: begin
        if (s.bvalid && s.bready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Address/data handshakes are remembered so a held valid cannot issue twice.
  always_comb begin
    ar_done_d = 1'b0;
    aw_done_d = 1'b0;
    w_done_d  = 1'b0;
    if (state_q != IDLE) begin
      ar_done_d = ar_done_q | (s.arvalid & s.arready);
      aw_done_d = aw_done_q | (s.awvalid & s.awready);
      w_done_d  = w_done_q  | (s.wvalid  & s.wready);
    end
  end

  // Watchdog: counts open-transaction cycles, saturates, flag is sticky until reset.
  always_comb begin
    hang_cnt_d = '0;
    if (state_q != IDLE) begin
      hang_cnt_d = (hang_cnt_q == CNT_MAX) ? hang_cnt_q : hang_cnt_q + CNT_W'(1);
    end
    hang_flag_d = hang_flag_q | (hang_cnt_d == CNT_MAX);
  end

  // Channel routing for the granted master; everything else is held quiet.
  always_comb begin
    s.araddr    = lsu.araddr;
    s.arsize    = lsu.arsize;
    s.arvalid   = 1'b0;
    s.rready    = 1'b0;
    s.awaddr    = lsu.awaddr;
    s.awsize    = lsu.awsize;
    s.awvalid   = 1'b0;
    s.wdata     = lsu.wdata;
    s.wstrb     = lsu.wstrb;
    s.wvalid    = 1'b0;
    s.bready    = 1'b0;

    ifu.arready = 1'b0;
    ifu.rdata   = s.rdata;
    ifu.rresp   = s.rresp;
    ifu.rvalid  = 1'b0;
    ifu.awready = 1'b0;
    ifu.wready  = 1'b0;
    ifu.bresp   = s.bresp;
    ifu.bvalid  = 1'b0;

    lsu.arready = 1'b0;
    lsu.rdata   = s.rdata;
    lsu.rresp   = s.rresp;
    lsu.rvalid  = 1'b0;
    lsu.awready = 1'b0;
    lsu.wready  = 1'b0;
    lsu.bresp   = s.bresp;
    lsu.bvalid  = 1'b0;

    unique case (state_q)
      IFU_RD: begin
        s.araddr    = ifu.araddr;
        s.arsize    = IFU_SIZE;
        s.arvalid   = ifu.arvalid & ~ar_done_q;
        ifu.arready = s.arready & ~ar_done_q;
        ifu.rvalid  = s.rvalid;
        s.rready    = ifu.rready;
      end
      LSU_RD: begin
        s.arvalid   = lsu.arvalid & ~ar_done_q;
        lsu.arready = s.arready & ~ar_done_q;
        lsu.rvalid  = s.rvalid;
        s.rready    = lsu.rready;
      end
      LSU_WR: begin
        s.awvalid   = lsu.awvalid & ~aw_done_q;
        lsu.awready = s.awready & ~aw_done_q;
        s.wvalid    = lsu.wvalid & ~w_done_q;
        lsu.wready  = s.wready & ~w_done_q;
        lsu.bvalid  = s.bvalid;
        s.bready    = lsu.bready;
      end
      default: ;
    endcase
  end
endmodule

// File: tb/tb_ysyx_23060236_mem_arbiter.sv
// Directed bench: round-robin instance (dut_a) and fixed-priority instance (dut_b), both HANG_CYCLES=16.
module tb_ysyx_23060236_mem_arbiter;
  logic clock = 1'b0;
  logic reset;
  logic hang_a, hang_b;
  int   vectors = 0;
  int   miscompares = 0;

  always #5 clock = ~clock;

  ysyx_23060236_mem_arbiter_if ifu_a ();
  ysyx_23060236_mem_arbiter_if lsu_a ();
  ysyx_23060236_mem_arbiter_if s_a ();
  ysyx_23060236_mem_arbiter_if ifu_b ();
  ysyx_23060236_mem_arbiter_if lsu_b ();
  ysyx_23060236_mem_arbiter_if s_b ();

  ysyx_23060236_mem_arbiter #(.RR_EN(1'b1), .HANG_CYCLES(16)) dut_a (
    .clock(clock), .reset(reset), .ifu(ifu_a), .lsu(lsu_a), .s(s_a), .hang_flag(hang_a));
  ysyx_23060236_mem_arbiter #(.RR_EN(1'b0), .HANG_CYCLES(16)) dut_b (
    .clock(clock), .reset(reset), .ifu(ifu_b), .lsu(lsu_b), .s(s_b), .hang_flag(hang_b));

  // Handshake outputs packed for compact checks
  localparam logic [14:0] H_IFU_AWREADY = 15'h4000;
  localparam logic [14:0] H_IFU_WREADY  = 15'h2000;
  localparam logic [14:0] H_IFU_BVALID  = 15'h1000;
  localparam logic [14:0] H_IFU_ARREADY = 15'h0800;
  localparam logic [14:0] H_IFU_RVALID  = 15'h0400;
  localparam logic [14:0] H_LSU_ARREADY = 15'h0200;
  localparam logic [14:0] H_LSU_RVALID  = 15'h0100;
  localparam logic [14:0] H_LSU_AWREADY = 15'h0080;
  localparam logic [14:0] H_LSU_WREADY  = 15'h0040;
  localparam logic [14:0] H_LSU_BVALID  = 15'h0020;
  localparam logic [14:0] H_S_ARVALID   = 15'h0010;
  localparam logic [14:0] H_S_RREADY    = 15'h0008;
  localparam logic [14:0] H_S_AWVALID   = 15'h0004;
  localparam logic [14:0] H_S_WVALID    = 15'h0002;
  localparam logic [14:0] H_S_BREADY    = 15'h0001;
  localparam logic [14:0] H_IFU_RD = H_IFU_ARREADY | H_IFU_RVALID | H_S_ARVALID | H_S_RREADY;
  localparam logic [14:0] H_LSU_RD = H_LSU_ARREADY | H_LSU_RVALID | H_S_ARVALID | H_S_RREADY;

  logic [14:0] hs_a, hs_b;
  assign hs_a = {ifu_a.awready, ifu_a.wready, ifu_a.bvalid, ifu_a.arready, ifu_a.rvalid,
                 lsu_a.arready, lsu_a.rvalid, lsu_a.awready, lsu_a.wready, lsu_a.bvalid,
                 s_a.arvalid, s_a.rready, s_a.awvalid, s_a.wvalid, s_a.bready};
  assign hs_b = {ifu_b.awready, ifu_b.wready, ifu_b.bvalid, ifu_b.arready, ifu_b.rvalid,
                 lsu_b.arready, lsu_b.rvalid, lsu_b.awready, lsu_b.wready, lsu_b.bvalid,
                 s_b.arvalid, s_b.rready, s_b.awvalid, s_b.wvalid, s_b.bready};

  logic unused_tb;
  assign unused_tb = ^{ifu_a.rdata, ifu_a.rresp, ifu_a.bresp, lsu_a.rdata, lsu_a.rresp, lsu_a.bresp,
                       s_a.araddr, s_a.arsize, s_a.awaddr, s_a.awsize, s_a.wdata, s_a.wstrb,
                       ifu_b.rdata, ifu_b.rresp, ifu_b.bresp, lsu_b.rdata, lsu_b.rresp, lsu_b.bresp,
                       s_b.araddr, s_b.arsize, s_b.awaddr, s_b.awsize, s_b.wdata, s_b.wstrb,
                       hs_a, hs_b, hang_b};

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vectors++;
    assert (observed === expected)
    else begin
      miscompares++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
    end
  endtask

  initial begin
    reset = 1'b0;
    {ifu_a.araddr, ifu_a.arsize, ifu_a.arvalid, ifu_a.rready, ifu_a.awaddr, ifu_a.awsize,
     ifu_a.awvalid, ifu_a.wdata, ifu_a.wstrb, ifu_a.wvalid, ifu_a.bready} = '0;
    {lsu_a.araddr, lsu_a.arsize, lsu_a.arvalid, lsu_a.rready, lsu_a.awaddr, lsu_a.awsize,
     lsu_a.awvalid, lsu_a.wdata, lsu_a.wstrb, lsu_a.wvalid, lsu_a.bready} = '0;
    {ifu_b.araddr, ifu_b.arsize, ifu_b.arvalid, ifu_b.rready, ifu_b.awaddr, ifu_b.awsize,
     ifu_b.awvalid, ifu_b.wdata, ifu_b.wstrb, ifu_b.wvalid, ifu_b.bready} = '0;
    {lsu_b.araddr, lsu_b.arsize, lsu_b.arvalid, lsu_b.rready, lsu_b.awaddr, lsu_b.awsize,
     lsu_b.awvalid, lsu_b.wdata, lsu_b.wstrb, lsu_b.wvalid, lsu_b.bready} = '0;
    {s_a.arready, s_a.rdata, s_a.rresp, s_a.rvalid, s_a.awready, s_a.wready, s_a.bresp, s_a.bvalid} = '0;
    {s_b.arready, s_b.rdata, s_b.rresp, s_b.rvalid, s_b.awready, s_b.wready, s_b.bresp, s_b.bvalid} = '0;

    // Reset with every master valid and every slave handshake high
    ifu_a.araddr = 32'h3000_0000; ifu_a.arvalid = 1'b1; ifu_a.rready = 1'b1;
    lsu_a.arvalid = 1'b1; lsu_a.awvalid = 1'b1; lsu_a.wvalid = 1'b1;
    lsu_a.rready = 1'b1; lsu_a.bready = 1'b1;
    s_a.arready = 1'b1; s_a.awready = 1'b1; s_a.wready = 1'b1; s_a.rvalid = 1'b1; s_a.bvalid = 1'b1;
    tick(); #2;
    chk("rst_hs_1", 32'(hs_a), 32'h0);
    chk("rst_hang", 32'(hang_a), 32'h0);
    tick(); #2;
    chk("rst_hs_2", 32'(hs_a), 32'h0);

    // IFU read alone
    lsu_a.arvalid = 1'b0; lsu_a.awvalid = 1'b0; lsu_a.wvalid = 1'b0;
    s_a.arready = 1'b0; s_a.awready = 1'b0; s_a.wready = 1'b0; s_a.rvalid = 1'b0; s_a.bvalid = 1'b0;
    reset = 1'b1;
    #2;
    chk("idle_after_rst", 32'(hs_a), 32'h0);
    tick(); #2;
    chk("ifu_grant_hs", 32'(hs_a), 32'(H_S_ARVALID | H_S_RREADY));
    chk("ifu_araddr", s_a.araddr, 32'h3000_0000);
    chk("ifu_arsize", 32'(s_a.arsize), 32'h2);
    tick();
    tick(); s_a.arready = 1'b1; #2;
    chk("ifu_arready", 32'(hs_a), 32'(H_IFU_ARREADY | H_S_ARVALID | H_S_RREADY));
    tick(); ifu_a.arvalid = 1'b0; s_a.arready = 1'b0; #2;
    chk("ifu_ar_done", 32'(hs_a), 32'(H_S_RREADY));
    tick(); tick();
    tick(); s_a.rvalid = 1'b1; s_a.rdata = 32'h0000_0413; s_a.rresp = 2'b00; #2;
    chk("ifu_rvalid_hs", 32'(hs_a), 32'(H_IFU_RVALID | H_S_RREADY));
    chk("ifu_rdata", ifu_a.rdata, 32'h0000_0413);
    chk("ifu_rresp", 32'(ifu_a.rresp), 32'h0);
    tick(); #2;
    chk("ifu_rd_idle", 32'(hs_a), 32'h0);
    s_a.rvalid = 1'b0;

    // Short reset so the first tie goes to the IFU
    reset = 1'b0;
    tick(); reset = 1'b1;

    // Round-robin ties on dut_a
    ifu_a.araddr = 32'h1000_0000; ifu_a.arvalid = 1'b1;
    lsu_a.araddr = 32'h2000_0000; lsu_a.arsize = 3'b001; lsu_a.arvalid = 1'b1;
    s_a.arready = 1'b1; s_a.rvalid = 1'b1; s_a.rdata = 32'hA5A5_0001;
    for (int i = 0; i < 4; i++) begin
      tick(); #2;
      if (i % 2 == 0) begin
        chk("rr_addr_ifu", s_a.araddr, 32'h1000_0000);
        chk("rr_hs_ifu", 32'(hs_a), 32'(H_IFU_RD));
        chk("rr_size_ifu", 32'(s_a.arsize), 32'h2);
      end else begin
        chk("rr_addr_lsu", s_a.araddr, 32'h2000_0000);
        chk("rr_hs_lsu", 32'(hs_a), 32'(H_LSU_RD));
        chk("rr_size_lsu", 32'(s_a.arsize), 32'h1);
      end
      tick(); #2;
      chk("rr_idle", 32'(hs_a), 32'h0);
    end
    ifu_a.arvalid = 1'b0; lsu_a.arvalid = 1'b0; s_a.arready = 1'b0; s_a.rvalid = 1'b0;

    // Fixed priority ties on dut_b
    ifu_b.araddr = 32'h1000_0000; ifu_b.arvalid = 1'b1; ifu_b.rready = 1'b1;
    lsu_b.araddr = 32'h2000_0000; lsu_b.arsize = 3'b001; lsu_b.arvalid = 1'b1; lsu_b.rready = 1'b1;
    s_b.arready = 1'b1; s_b.rvalid = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick(); #2;
      chk("fp_addr_lsu", s_b.araddr, 32'h2000_0000);
      chk("fp_hs_lsu", 32'(hs_b), 32'(H_LSU_RD));
      tick(); #2;
      chk("fp_idle", 32'(hs_b), 32'h0);
    end
    lsu_b.arvalid = 1'b0;
    tick(); #2;
    chk("fp_addr_ifu", s_b.araddr, 32'h1000_0000);
    chk("fp_hs_ifu", 32'(hs_b), 32'(H_IFU_RD));
    tick();
    ifu_b.arvalid = 1'b0; s_b.arready = 1'b0; s_b.rvalid = 1'b0;

    // LSU store while the IFU waits; wready precedes awready
    lsu_a.awaddr = 32'h8000_0004; lsu_a.awsize = 3'b010; lsu_a.awvalid = 1'b1;
    lsu_a.wdata = 32'hDEAD_BEEF; lsu_a.wstrb = 4'hF; lsu_a.wvalid = 1'b1;
    ifu_a.araddr = 32'h3000_0010; ifu_a.arvalid = 1'b1; s_a.arready = 1'b1;
    tick(); #2;
    chk("wr_grant_hs", 32'(hs_a), 32'(H_S_AWVALID | H_S_WVALID | H_S_BREADY));
    chk("wr_awaddr", s_a.awaddr, 32'h8000_0004);
    chk("wr_wdata", s_a.wdata, 32'hDEAD_BEEF);
    chk("wr_wstrb", 32'(s_a.wstrb), 32'hF);
    s_a.wready = 1'b1; #2;
    chk("wr_wready", 32'(hs_a), 32'(H_S_AWVALID | H_S_WVALID | H_S_BREADY | H_LSU_WREADY));
    tick(); lsu_a.wvalid = 1'b0; s_a.wready = 1'b0; s_a.awready = 1'b1; #2;
    chk("wr_awready", 32'(hs_a), 32'(H_S_AWVALID | H_S_BREADY | H_LSU_AWREADY));
    tick(); lsu_a.awvalid = 1'b0; s_a.awready = 1'b0; s_a.bvalid = 1'b1; s_a.bresp = 2'b10; #2;
    chk("wr_bvalid_hs", 32'(hs_a), 32'(H_S_BREADY | H_LSU_BVALID));
    chk("wr_bresp", 32'(lsu_a.bresp), 32'h2);
    tick(); s_a.bvalid = 1'b0; #2;
    chk("wr_idle", 32'(hs_a), 32'h0);

    // IFU granted next; slave then withholds rvalid to trip the watchdog
    tick(); #2;
    chk("post_wr_ifu_hs", 32'(hs_a), 32'(H_IFU_ARREADY | H_S_ARVALID | H_S_RREADY));
    chk("post_wr_ifu_addr", s_a.araddr, 32'h3000_0010);
    tick(); ifu_a.arvalid = 1'b0; s_a.arready = 1'b0;
    repeat (14) tick();
    #2;
    chk("hang_before", 32'(hang_a), 32'h0);
    tick(); #2;
    chk("hang_set", 32'(hang_a), 32'h1);
    s_a.rvalid = 1'b1; #2;
    chk("late_rvalid_hs", 32'(hs_a), 32'(H_IFU_RVALID | H_S_RREADY));
    tick(); s_a.rvalid = 1'b0; #2;
    chk("hang_sticky_idle", 32'(hang_a), 32'h1);
    chk("late_idle_hs", 32'(hs_a), 32'h0);

    // Reset taken in LSU_RD after the address handshake
    lsu_a.araddr = 32'h8000_0100; lsu_a.arsize = 3'b000; lsu_a.arvalid = 1'b1; s_a.arready = 1'b1;
    tick(); #2;
    chk("lsu_rd_hs", 32'(hs_a), 32'(H_LSU_ARREADY | H_S_ARVALID | H_S_RREADY));
    chk("lsu_rd_size", 32'(s_a.arsize), 32'h0);
    tick(); lsu_a.arvalid = 1'b0; s_a.arready = 1'b0; s_a.rvalid = 1'b1; #2;
    chk("lsu_rvalid_hs", 32'(hs_a), 32'(H_LSU_RVALID | H_S_RREADY));
    chk("hang_sticky_rd", 32'(hang_a), 32'h1);
    reset = 1'b0;
    tick(); #2;
    chk("mid_rst_hs", 32'(hs_a), 32'h0);
    chk("mid_rst_hang", 32'(hang_a), 32'h0);
    reset = 1'b1; s_a.rvalid = 1'b0;
    tick(); #2;
    chk("final_idle_hs", 32'(hs_a), 32'h0);
    chk("fp_hang", 32'(hang_b), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
